binary_to_bcd_converter: RTL and testbench

Sequential shift-add-3 (double-dabble) converter that turns a 14-bit unsigned binary value into four packed BCD digits. It sits directly upstream of the 4-digit seven-segment multiplexer and drives that block's 16-bit data input, so decimal values display as 0000-9999 instead of hex. One conversion per start pulse. Fixed 15-cycle latency. Results above 9999 saturate.

---
 rtl/binary_to_bcd_converter.sv | 126 ++++++++++++
 tb/tb_binary_to_bcd_converter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_converter.sv
// Sequential shift-add-3 (double-dabble) binary to packed BCD converter.
// A 14-bit unsigned value becomes four BCD digits after a fixed 15-cycle latency.
// Values above 9999 saturate to 9999 and raise overflow.
module binary_to_bcd_converter #(
    parameter int unsigned BIN_WIDTH  = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_WIDTH-1:0]      bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int unsigned BCD_WIDTH = 4 * NUM_DIGITS;
    // One extra scratch digit catches results above the displayable range.
    localparam int unsigned SC_WIDTH  = 4 * (NUM_DIGITS + 1);
    localparam int unsigned SC_DIGITS = NUM_DIGITS + 1;
    localparam int unsigned CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(BIN_WIDTH - 1);
    localparam logic [BCD_WIDTH-1:0] SAT_VALUE = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [BIN_WIDTH-1:0]   sh, sh_n;
    logic [SC_WIDTH-1:0]    sc, sc_n, sc_adj;
    logic [CNT_WIDTH-1:0]   cnt, cnt_n;
    logic [BCD_WIDTH-1:0]   bcd_n;
    logic                   overflow_n;
    logic                   done_n;
    logic                   busy_n;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_n    = state;
        sh_n       = sh;
        sc_n       = sc;
        cnt_n      = cnt;
        bcd_n      = bcd;
        overflow_n = overflow;
        done_n     = 1'b0;
        sc_adj     = sc;

        // Add 3 to every digit >= 5, all digits judged on the pre-shift value.
        for (int d = 0; d < SC_DIGITS; d++) begin
            if (sc[4*d +: 4] >= 4'd5) begin
                sc_adj[4*d +: 4] = sc[4*d +: 4] + 4'd3;
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    sh_n    = bin;
                    sc_n    = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sc_n  = {sc_adj[SC_WIDTH-2:0], sh[BIN_WIDTH-1]};
                sh_n  = {sh[BIN_WIDTH-2:0], 1'b0};
                cnt_n = cnt + CNT_WIDTH'(1);
                if (cnt == LAST_ITER) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (sc[SC_WIDTH-1 -: 4] != 4'd0) begin
                    bcd_n      = SAT_VALUE;
                    overflow_n = 1'b1;
                end else begin
                    bcd_n      = sc[BCD_WIDTH-1:0];
                    overflow_n = 1'b0;
                end
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // busy stays up through the cycle in which done is presented.
        busy_n = (state_n != IDLE) || (state == DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh       <= '0;
            sc       <= '0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sh       <= sh_n;
            sc       <= sc_n;
            cnt      <= cnt_n;
            bcd      <= bcd_n;
            overflow <= overflow_n;
            done     <= done_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench for binary_to_bcd_converter: directed cases plus a
// randomized back-to-back run checked against a decimal reference model.
module tb_binary_to_bcd_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    binary_to_bcd_converter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: saturate at 9999, then split into decimal digits.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion: start accepted at edge k, done expected after edge k+15.
    task automatic convert(input int v);
        int n;
        @(negedge clk);
        bin   = 14'(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 14'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'd15);
        check("bcd", 32'(bcd), 32'(ref_bcd(v)));
        check("overflow", 32'(overflow), 32'(v > 9999));
        check("busy_at_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("done_single_cycle", 32'(done), 32'd0);
        check("busy_low_after", 32'(busy), 32'd0);
        check("bcd_hold", 32'(bcd), 32'(ref_bcd(v)));
    endtask

    initial begin
        int ndone;
        int done_edge;
        int samples[$];
        int idx;

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed values including the saturation boundary.
        convert(0);
        convert(1234);
        convert(9999);
        convert(10000);
        convert(16383);
        convert(42);

        // Start ignored while busy; bin changes after capture have no effect.
        @(negedge clk);
        bin   = 14'd5678;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        done_edge = 0;
        for (int e = 1; e <= 20; e++) begin
            start = (e == 5 || e == 15);
            bin   = (e == 5 || e == 15) ? 14'd1111 : 14'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                done_edge = e;
                check("ignored_start_bcd", 32'(bcd), 32'h5678);
            end
        end
        check("ignored_start_ndone", 32'(ndone), 32'd1);
        check("ignored_start_edge", 32'(done_edge), 32'd15);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Reset mid-conversion aborts it without a done pulse.
        @(negedge clk);
        bin   = 14'd4321;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_busy_idle", 32'(busy), 32'd0);
        convert(8765);

        // Start held high: a conversion every 16 cycles, bin captured at each accept.
        for (int i = 0; i < 500; i++) samples.push_back(int'($urandom_range(0, 9999)));
        @(negedge clk);
        for (int c = 0; c < 16 * 500; c++) begin
            start = 1'b1;
            bin   = (c % 16 == 0) ? 14'(samples[c / 16]) : 14'($urandom);
            @(posedge clk); #1;
            if (c == 16 * 500 - 1) start = 1'b0;
            check("b2b_done", 32'(done), 32'(c % 16 == 15));
            if (done && (c % 16 == 15)) begin
                idx = c / 16;
                check("b2b_bcd", 32'(bcd), 32'(ref_bcd(samples[idx])));
                check("b2b_ovf", 32'(overflow), 32'd0);
            end
        end
        @(posedge clk); #1;
        check("b2b_tail_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("b2b_tail_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
